// File: rtl/burst_sequencer_if.sv
// Handshake and configuration bundle between the pattern controller and burst_sequencer.
// master drives start/enable/abort/config; slave returns pattern, status and counters.
interface burst_sequencer_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic             enable;
    logic             abort;
    logic [CNT_W-1:0] n_cfg;
    logic [CNT_W-1:0] m_cfg;
    logic [CNT_W-1:0] gap_cfg;
    logic             out;
    logic             busy;
    logic             done;
    logic             cfg_err;
    logic [CNT_W-1:0] n_cnt;
    logic [CNT_W-1:0] m_cnt;

    modport master (
        output start, enable, abort, n_cfg, m_cfg, gap_cfg,
        input  out, busy, done, cfg_err, n_cnt, m_cnt
    );

    modport slave (
        input  start, enable, abort, n_cfg, m_cfg, gap_cfg,
        output out, busy, done, cfg_err, n_cnt, m_cnt
    );
endinterface

// File: rtl/burst_sequencer.sv
// Programmable burst-pattern sequencer: M bursts of N out pulses separated by G idle
// cycles, followed by a one-cycle done pulse; enable stretches the pattern, abort cancels it.
module burst_sequencer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    burst_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_e;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_e           state_q,   state_d;
    logic [CNT_W-1:0] n_cnt_q,   n_cnt_d;
    logic [CNT_W-1:0] m_cnt_q,   m_cnt_d;
    logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0] n_lat_q,   n_lat_d;
    logic [CNT_W-1:0] m_lat_q,   m_lat_d;
    logic [CNT_W-1:0] g_lat_q,   g_lat_d;
    logic             done_q,    done_d;
    logic             cfg_err_q, cfg_err_d;

    logic n_last;
    logic m_last;
    logic g_last;
    logic cfg_ok;

    // Terminal compares against latched-minus-one so counters stop before they could wrap.
    assign n_last = (n_cnt_q == n_lat_q - ONE);
    assign m_last = (m_cnt_q == m_lat_q - ONE);
    assign g_last = (gap_cnt_q == g_lat_q - ONE);
    assign cfg_ok = (bus.n_cfg != '0) && (bus.m_cfg != '0);

    always_comb begin
        state_d   = state_q;
        n_cnt_d   = n_cnt_q;
        m_cnt_d   = m_cnt_q;
        gap_cnt_d = gap_cnt_q;
        n_lat_d   = n_lat_q;
        m_lat_d   = m_lat_q;
        g_lat_d   = g_lat_q;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;

        if (bus.abort) begin
            state_d   = IDLE;
            n_cnt_d   = '0;
            m_cnt_d   = '0;
            gap_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (cfg_ok) begin
                            n_lat_d   = bus.n_cfg;
                            m_lat_d   = bus.m_cfg;
                            g_lat_d   = bus.gap_cfg;
                            n_cnt_d   = '0;
                            m_cnt_d   = '0;
                            gap_cnt_d = '0;
                            state_d   = RUN;
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.enable) begin
                        if (!n_last) begin
                            n_cnt_d = n_cnt_q + ONE;
                        end else if (m_last) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            n_cnt_d = '0;
                            m_cnt_d = m_cnt_q + ONE;
                            if (g_lat_q != '0) begin
                                gap_cnt_d = '0;
                                state_d   = GAP;
                            end
                        end
                    end
                end
                GAP: begin
                    if (bus.enable) begin
                        if (g_last) begin
                            state_d = RUN;
                        end else begin
                            gap_cnt_d = gap_cnt_q + ONE;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            n_cnt_q   <= '0;
            m_cnt_q   <= '0;
            gap_cnt_q <= '0;
            n_lat_q   <= '0;
            m_lat_q   <= '0;
            g_lat_q   <= '0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_cnt_q   <= n_cnt_d;
            m_cnt_q   <= m_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            n_lat_q   <= n_lat_d;
            m_lat_q   <= m_lat_d;
            g_lat_q   <= g_lat_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign bus.out     = (state_q == RUN) && bus.enable;
    assign bus.busy    = (state_q == RUN) || (state_q == GAP);
    assign bus.done    = done_q;
    assign bus.cfg_err = cfg_err_q;
    assign bus.n_cnt   = n_cnt_q;
    assign bus.m_cnt   = m_cnt_q;
endmodule

// File: tb/tb_burst_sequencer.sv
// Bench for burst_sequencer: directed scenarios plus randomized traffic, all checked
// against a token-queue reference model of the burst pattern.
module tb_burst_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    burst_sequencer_if #(.CNT_W(4)) bus();

    burst_sequencer #(.CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    wire [11:0] dut_vec = {bus.out, bus.busy, bus.done, bus.cfg_err, bus.n_cnt, bus.m_cnt};

    // Reference model: a started sequence is a queue of slot tokens (pulse or gap);
    // each enabled busy cycle consumes one token, and done follows the last one.
    // token = {is_pulse[16], burst[15:8], pulse_idx[7:0]}
    int         q[$];
    int         phase;      // 0 idle, 1 active, 2 done
    int         mn, mm;
    bit         err_pend;
    logic [11:0] exp_vec;

    task automatic model_reset();
        q.delete();
        phase = 0; mn = 0; mm = 0; err_pend = 1'b0;
    endtask

    task automatic model_eval(input bit st, input bit en, input bit ab,
                              input int n, input int m, input int g);
        bit e_out, e_busy, e_done;
        int tok;
        e_out = 1'b0; e_busy = 1'b0; e_done = (phase == 2);
        if (phase == 1) begin
            tok    = q[0];
            mn     = tok & 255;
            mm     = (tok >> 8) & 255;
            e_busy = 1'b1;
            e_out  = en && tok[16];
        end
        exp_vec  = {e_out, e_busy, e_done, err_pend, mn[3:0], mm[3:0]};
        err_pend = 1'b0;
        if (ab) begin
            q.delete(); phase = 0; mn = 0; mm = 0;
        end else if (phase == 0) begin
            if (st) begin
                if (n != 0 && m != 0) begin
                    for (int b = 0; b < m; b++) begin
                        if (b > 0) for (int k = 0; k < g; k++) q.push_back(b << 8);
                        for (int i = 0; i < n; i++) q.push_back((1 << 16) | (b << 8) | i);
                    end
                    phase = 1; mn = 0; mm = 0;
                end else begin
                    err_pend = 1'b1;
                end
            end
        end else if (phase == 1) begin
            if (en) begin
                void'(q.pop_front());
                if (q.size() == 0) phase = 2;
            end
        end else begin
            phase = 0;
        end
    endtask

    task automatic drive_cycle(input bit st, input bit en, input bit ab,
                               input int n, input int m, input int g);
        @(posedge clk); #1;
        bus.start   = st;
        bus.enable  = en;
        bus.abort   = ab;
        bus.n_cfg   = n[3:0];
        bus.m_cfg   = m[3:0];
        bus.gap_cfg = g[3:0];
        model_eval(st, en, ab, n, m, g);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0; bus.enable = 1'b1; bus.abort = 1'b0;
        bus.n_cfg = '0; bus.m_cfg = '0; bus.gap_cfg = '0;
        #2 reset = 1'b0;
        #1;
        tests++;
        if (dut_vec !== 12'h000) begin
            fails++; $display("FAIL reset_state got=%h exp=%h", dut_vec, 12'h000);
        end
        model_reset();
        @(posedge clk); @(posedge clk); #3 reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            drive_cycle(1'b0, 1'b1, 1'b0, 0, 0, 0);
            #2; tests++;
            if (dut_vec !== exp_vec) begin
                fails++; $display("FAIL reset_idle c%0d got=%h exp=%h", c, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_basic();
        int done_at = -1, pulses = 0;
        for (int c = 0; c < 10; c++) begin
            drive_cycle(c == 0, 1'b1, 1'b0, 3, 2, 0);
            #2; tests++;
            if (dut_vec !== exp_vec) begin
                fails++; $display("FAIL basic c%0d got=%h exp=%h", c, dut_vec, exp_vec);
            end
            if (bus.out) pulses++;
            if (bus.done && done_at < 0) done_at = c;
        end
        tests++; if (done_at != 7) begin fails++; $display("FAIL basic_done_cycle got=%0d exp=7", done_at); end
        tests++; if (pulses != 6) begin fails++; $display("FAIL basic_pulses got=%0d exp=6", pulses); end
    endtask

    task automatic test_gap();
        int done_at = -1, pulses = 0;
        for (int c = 0; c < 12; c++) begin
            drive_cycle(c == 0, 1'b1, 1'b0, 3, 2, 2);
            #2; tests++;
            if (dut_vec !== exp_vec) begin
                fails++; $display("FAIL gap c%0d got=%h exp=%h", c, dut_vec, exp_vec);
            end
            if (bus.out) pulses++;
            if (bus.done && done_at < 0) done_at = c;
        end
        tests++; if (done_at != 9) begin fails++; $display("FAIL gap_done_cycle got=%0d exp=9", done_at); end
        tests++; if (pulses != 6) begin fails++; $display("FAIL gap_pulses got=%0d exp=6", pulses); end
    endtask

    task automatic test_max();
        int done_at = -1, pulses = 0, bad = 0;
        for (int c = 0; c < 440; c++) begin
            drive_cycle(c == 0, 1'b1, 1'b0, 15, 15, 15);
            #2;
            if (dut_vec !== exp_vec) begin
                bad++;
                if (bad <= 3) $display("FAIL max c%0d got=%h exp=%h", c, dut_vec, exp_vec);
            end
            if (bus.out) pulses++;
            if (bus.done && done_at < 0) done_at = c;
        end
        tests++; if (bad != 0) fails++;
        tests++; if (done_at != 436) begin fails++; $display("FAIL max_done_cycle got=%0d exp=436", done_at); end
        tests++; if (pulses != 225) begin fails++; $display("FAIL max_pulses got=%0d exp=225", pulses); end
    endtask

    task automatic test_cfg_err();
        int errs = 0, done_at = -1, n, m;
        for (int c = 0; c < 11; c++) begin
            n = (c == 0) ? 0 : 2;
            m = (c == 1) ? 0 : 2;
            drive_cycle(c <= 2, 1'b1, 1'b0, n, m, 1);
            #2; tests++;
            if (dut_vec !== exp_vec) begin
                fails++; $display("FAIL cfg_err c%0d got=%h exp=%h", c, dut_vec, exp_vec);
            end
            if (bus.cfg_err) errs++;
            if (bus.done && done_at < 0) done_at = c;
        end
        tests++; if (errs != 2) begin fails++; $display("FAIL cfg_err_pulses got=%0d exp=2", errs); end
        tests++; if (done_at != 8) begin fails++; $display("FAIL cfg_err_done_cycle got=%0d exp=8", done_at); end
    endtask

    task automatic test_enable();
        int done_at = -1, pulses = 0;
        bit en;
        for (int c = 0; c < 16; c++) begin
            en = !(c >= 3 && c <= 5);
            drive_cycle(c == 0, en, 1'b0, 4, 2, 1);
            #2; tests++;
            if (dut_vec !== exp_vec) begin
                fails++; $display("FAIL enable c%0d got=%h exp=%h", c, dut_vec, exp_vec);
            end
            if (!en && (bus.n_cnt !== 4'd2 || bus.out !== 1'b0)) begin
                fails++; $display("FAIL enable_hold c%0d n_cnt=%0d out=%b exp n_cnt=2 out=0", c, bus.n_cnt, bus.out);
            end
            if (bus.out) pulses++;
            if (bus.done && done_at < 0) done_at = c;
        end
        tests++; if (done_at != 13) begin fails++; $display("FAIL enable_done_cycle got=%0d exp=13", done_at); end
        tests++; if (pulses != 8) begin fails++; $display("FAIL enable_pulses got=%0d exp=8", pulses); end
    endtask

    task automatic test_abort();
        int dones = 0;
        for (int c = 0; c < 14; c++) begin
            drive_cycle(c == 0, 1'b1, c == 4, 3, 3, 0);
            #2; tests++;
            if (dut_vec !== exp_vec) begin
                fails++; $display("FAIL abort c%0d got=%h exp=%h", c, dut_vec, exp_vec);
            end
            if (bus.done) dones++;
            if (c == 5 && {bus.busy, bus.n_cnt, bus.m_cnt} !== 9'h000) begin
                fails++; $display("FAIL abort_idle got busy=%b n=%0d m=%0d exp all 0", bus.busy, bus.n_cnt, bus.m_cnt);
            end
        end
        tests++; if (dones != 0) begin fails++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 5; c++) begin
            drive_cycle(c == 0, 1'b1, 1'b0, 3, 2, 1);
        end
        #2 reset = 1'b0;
        #1; tests++;
        if (dut_vec !== 12'h000) begin
            fails++; $display("FAIL async_reset got=%h exp=%h", dut_vec, 12'h000);
        end
        model_reset();
        bus.start = 1'b0;
        @(posedge clk); #3 reset = 1'b1;
        drive_cycle(1'b0, 1'b1, 1'b0, 0, 0, 0);
        #2; tests++;
        if (dut_vec !== exp_vec) begin
            fails++; $display("FAIL async_reset_after got=%h exp=%h", dut_vec, exp_vec);
        end
    endtask

    task automatic test_back_to_back();
        int first = -1, second = -1;
        for (int c = 0; c < 9; c++) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 2, 1, 0);
            #2; tests++;
            if (dut_vec !== exp_vec) begin
                fails++; $display("FAIL b2b c%0d got=%h exp=%h", c, dut_vec, exp_vec);
            end
            if (bus.done) begin
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
        end
        tests++;
        if (first != 3 || second != 7) begin
            fails++; $display("FAIL b2b_done got=%0d,%0d exp=3,7", first, second);
        end
        drive_cycle(1'b0, 1'b1, 1'b0, 0, 0, 0);
        drive_cycle(1'b0, 1'b1, 1'b0, 0, 0, 0);
    endtask

    task automatic test_random();
        int bad = 0, n, m, g;
        bit st, en, ab;
        for (int c = 0; c < 2000; c++) begin
            st = ($urandom_range(0, 9) < 3);
            en = ($urandom_range(0, 99) < 85);
            ab = ($urandom_range(0, 99) < 3);
            n  = ($urandom_range(0, 11) == 0) ? 0 : $urandom_range(1, 5);
            m  = ($urandom_range(0, 11) == 0) ? 0 : $urandom_range(1, 4);
            g  = $urandom_range(0, 3);
            drive_cycle(st, en, ab, n, m, g);
            #2; tests++;
            if (dut_vec !== exp_vec) begin
                fails++; bad++;
                if (bad <= 5) $display("FAIL random c%0d got=%h exp=%h", c, dut_vec, exp_vec);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_gap();
        test_max();
        test_cfg_err();
        test_enable();
        test_abort();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/burst_sequencer.md
Name: burst_sequencer

Overview:
- Programmable burst-pattern sequencer.
- On start, emits M bursts of N consecutive `out` pulses, with G idle cycles between bursts, then pulses `done`.
- Owns its own nested N/M/gap counters, replacing discrete counter plus counter-control pairs in the pattern-generation path.
- Provides a start/busy/done handshake toward the top-level controller.

Parameters:
- CNT_W, 4, width of the n/m/gap configuration fields and counters.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request a new sequence; sampled only in IDLE.
- enable  input  1  hold control; 0 freezes counters and state in RUN/GAP.
- abort  input  1  synchronous cancel of the current sequence.
- n_cfg  input  CNT_W  pulses per burst (N).
- m_cfg  input  CNT_W  bursts per sequence (M).
- gap_cfg  input  CNT_W  idle cycles between bursts (G); 0 means bursts run back-to-back.
- out  output  1  pattern output.
- busy  output  1  high in RUN and GAP.
- done  output  1  one-cycle completion pulse.
- cfg_err  output  1  one-cycle pulse when start is rejected.
- n_cnt  output  CNT_W  current pulse index within the burst.
- m_cnt  output  CNT_W  current burst index.

Behaviour:
- **Reset (reset=0, asynchronous):**
  - state=IDLE.
  - n_cnt, m_cnt, gap counter and latched cfg = 0.
  - done=0, cfg_err=0, busy=0, out=0.
  - Applies immediately, including mid-sequence.
- **States:** IDLE, RUN, GAP, DONE. State, counters, done and cfg_err are registered. out and busy decode combinationally from state.
  - out = (state==RUN) && enable.
  - busy = (state==RUN || state==GAP).
- **IDLE:**
  - start=1 with n_cfg!=0 and m_cfg!=0: latch n_cfg, m_cfg and gap_cfg; clear counters; next state RUN.
  - start=1 with n_cfg==0 or m_cfg==0: cfg_err=1 for the next cycle; remain in IDLE; nothing is latched.
- **RUN, enable=1:** each cycle is one out pulse.
  - n_cnt != N-1: n_cnt++.
  - n_cnt == N-1 and m_cnt == M-1: next state DONE.
  - n_cnt == N-1, other bursts remain, G==0: n_cnt=0, m_cnt++, stay in RUN.
  - n_cnt == N-1, other bursts remain, G!=0: n_cnt=0, m_cnt++, gap counter=0, next state GAP.
- **GAP, enable=1:**
  - out=0.
  - Gap counter increments each cycle.
  - When the gap counter reaches G-1, next state RUN.
- **enable=0 in RUN/GAP:**
  - All counters and state hold.
  - out=0.
  - The pulse count is unaffected; the sequence is stretched.
- **DONE:** done=1 for exactly one cycle, independent of enable; next state IDLE.
- **abort=1:**
  - Valid in any state.
  - Next state IDLE, all counters cleared, no done pulse.
  - Takes priority over start, enable and the terminal conditions.
- **Ignored inputs:**
  - start in RUN, GAP or DONE.
  - cfg input changes while busy; latched values are used.
- **Timing with enable held at 1:**
  - start sampled at edge 0 → out high during RUN cycles starting at cycle 1.
  - Total busy cycles = N*M + (M-1)*G.
  - done in the cycle after the last busy cycle.
  - A new start is accepted in the cycle after done.
- **Width rules:**
  - Comparisons use CNT_W-bit latched values; N, M and G range 1..2^CNT_W-1 (G from 0).
  - Counters never wrap: terminal compares fire before overflow.

Test Plan:
- n=3, m=2, gap=0, start at cycle 0 → out=1 in cycles 1–6; done=1 in cycle 7 only; busy=1 in cycles 1–6; m_cnt=1 in cycles 4–6.
- n=3, m=2, gap=2 → out=1 in cycles 1–3 and 6–8; out=0 in cycles 4–5 with busy=1; done in cycle 9.
- n=15, m=15, gap=15 (maxima) → 225 out pulses; done at cycle 436; no counter wrap; state IDLE at cycle 437.
- n=0 or m=0 with start → cfg_err pulse in cycle 1; busy stays 0; no out; a subsequent valid start works normally.
- n=4, m=2, gap=1, enable=0 for cycles 3–5 → out=0 and n_cnt held at 2 during those cycles; pulse total still 8; done delayed by 3 cycles versus baseline (cycle 13).
- Mid-sequence stimulus:
  - abort at cycle 4 of n=3, m=3 → IDLE at cycle 5, no done, counters 0.
  - reset low at cycle 4 → out, busy and counters 0 immediately (asynchronously), before the next clock edge.
